// File: rtl/apb_cmd_bridge.sv
// Single-command to APB master bridge: IDLE -> SETUP -> ACCESS with back-to-back chaining.
// Optional ACCESS wait-state timeout is enabled by defining APB_CMD_BRIDGE_TIMEOUT_EN.
module apb_cmd_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    // state  | meaning
    // IDLE   | no transfer, command accepted here
    // SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
    // ACCESS | PSEL=1, PENABLE=1 until PREADY (or timeout)
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef APB_CMD_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
`ifdef APB_CMD_BRIDGE_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_SETUP: begin
                PSEL    = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                req_ready = PREADY;
                if (PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = S_IDLE;
`ifdef APB_CMD_BRIDGE_TIMEOUT_EN
                end else if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Acceptance overrides the return to IDLE, giving the back-to-back path.
        if (req_valid && req_ready) begin
            state_d  = S_SETUP;
            pwrite_d = req_write;
            paddr_d  = req_addr;
            if (req_write) begin
                pwdata_d = req_wdata;
            end
`ifdef APB_CMD_BRIDGE_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_CMD_BRIDGE_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Bench for apb_cmd_bridge: directed scenarios plus randomized traffic against a transaction-level model.
module tb_apb_cmd_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    apb_cmd_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: a transfer is outstanding for some number of cycles since acceptance;
    // cycle 1 is the setup phase, every later cycle is an access phase.
    bit            m_busy = 1'b0;
    int            m_age = 0;
    int            m_wait = 0;
    bit            m_pwrite = 1'b0;
    logic [AW-1:0] m_paddr = '0;
    logic [DW-1:0] m_pwdata = '0;
    bit            m_rsp_valid = 1'b0;
    bit            m_rsp_err = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge PCLK or negedge PRESETn) begin : model
        bit in_acc, done, tmo, acc;
        if (!PRESETn) begin
            m_busy <= 1'b0; m_age <= 0; m_wait <= 0; m_pwrite <= 1'b0;
            m_paddr <= '0; m_pwdata <= '0; m_rsp_valid <= 1'b0; m_rsp_err <= 1'b0; m_rdata <= '0;
        end else begin
            in_acc = m_busy && (m_age >= 2);
            done   = in_acc && PREADY;
            tmo    = 1'b0;
`ifdef APB_CMD_BRIDGE_TIMEOUT_EN
            tmo    = in_acc && !PREADY && (m_wait + 1 >= TMO);
`endif
            acc    = req_valid && (!m_busy || done);
            m_rsp_valid <= done || tmo;
            if (done) begin
                m_rdata   <= m_pwrite ? '0 : PRDATA;
                m_rsp_err <= PSLVERR;
            end else if (tmo) begin
                m_rdata   <= '0;
                m_rsp_err <= 1'b1;
            end
            if (acc) begin
                m_busy <= 1'b1; m_age <= 1; m_wait <= 0;
                m_pwrite <= req_write; m_paddr <= req_addr;
                if (req_write) m_pwdata <= req_wdata;
            end else if (done || tmo) begin
                m_busy <= 1'b0;
            end else if (m_busy) begin
                m_age <= m_age + 1;
                if (in_acc) m_wait <= m_wait + 1;
            end
        end
    end

    always @(negedge PCLK) begin : compare
        logic e_psel, e_pen, e_rdy;
        if (chk_en) begin
            e_psel = m_busy;
            e_pen  = m_busy && (m_age >= 2);
            e_rdy  = !m_busy || ((m_age >= 2) && PREADY);
            n_cmp++;
            if ({PSEL, PENABLE, req_ready, rsp_valid, rsp_err, PWRITE} !==
                {e_psel, e_pen, e_rdy, m_rsp_valid, m_rsp_err, m_pwrite} ||
                PADDR !== m_paddr || PWDATA !== m_pwdata || rsp_rdata !== m_rdata) begin
                n_bad++;
                $display("FAIL model t=%0t got sel/en/rdy/rv/err/wr=%b%b%b%b%b%b addr=%h wd=%h rd=%h want %b%b%b%b%b%b addr=%h wd=%h rd=%h",
                         $time, PSEL, PENABLE, req_ready, rsp_valid, rsp_err, PWRITE, PADDR, PWDATA, rsp_rdata,
                         e_psel, e_pen, e_rdy, m_rsp_valid, m_rsp_err, m_pwrite, m_paddr, m_pwdata, m_rdata);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic cmd(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    endtask

    initial begin
        int k;
        cmd(0, 0, '0, '0);
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        PRESETn = 1'b1;
        #2 PRESETn = 1'b0;
        chk_en = 1'b1;
        step(); step();

        // reset values
        chk("rst_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, 5'b00000);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rdata", rsp_rdata, 0);

        // first command on first edge after release: write 0x4 / 0xDEADBEEF, zero wait
        PRESETn = 1'b1;
        cmd(1, 1, 32'h4, 32'hDEAD_BEEF);
        PREADY = 1'b1;
        chk("ready_after_rst", req_ready, 1);
        step(); req_valid = 1'b0;
        chk("w_setup", {PSEL, PENABLE}, 2'b10);
        step();
        chk("w_access", {PSEL, PENABLE}, 2'b11);
        chk("w_pwdata", PWDATA, 32'hDEAD_BEEF);
        step();
        chk("w_rsp", {rsp_valid, rsp_err, PSEL}, 3'b100);
        chk("w_rdata", rsp_rdata, 0);

        // read 0x4 with three wait states
        PREADY = 1'b0;
        cmd(1, 0, 32'h4, 32'h0);
        step(); req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r_hold", {PSEL, PENABLE, rsp_valid, PADDR}, {3'b110, 32'h4});
            if (i == 3) begin
                PREADY = 1'b1;
                PRDATA = 32'hDEAD_BEEF;
            end
        end
        step();
        chk("r_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("r_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("r_pwdata_kept", PWDATA, 32'hDEAD_BEEF);

        // back-to-back write 0x1/0x11 then read 0x2
        PREADY = 1'b1;
        cmd(1, 1, 32'h1, 32'h11);
        step();
        cmd(1, 0, 32'h2, 32'h0);
        chk("b2b_setup1", {PSEL, PENABLE}, 2'b10);
        step();
        chk("b2b_access1", {PSEL, PENABLE, req_ready}, 3'b111);
        step();
        req_valid = 1'b0;
        PRDATA = 32'h0000_2222;
        chk("b2b_setup2", {PSEL, PENABLE, rsp_valid, PADDR}, {3'b101, 32'h2});
        step();
        chk("b2b_access2", {PSEL, PENABLE, rsp_valid}, 3'b110);
        step();
        chk("b2b_rsp2", {rsp_valid, PSEL}, 2'b10);
        chk("b2b_rdata", rsp_rdata, 32'h2222);
        chk("b2b_pwdata", PWDATA, 32'h11);

        // slave error then clean completion
        PSLVERR = 1'b1;
        cmd(1, 0, 32'h8, 32'h0);
        step(); req_valid = 1'b0; step(); step();
        chk("err_set", {rsp_valid, rsp_err}, 2'b11);
        PSLVERR = 1'b0;
        cmd(1, 1, 32'h8, 32'h5);
        step(); req_valid = 1'b0; step(); step();
        chk("err_clr", {rsp_valid, rsp_err}, 2'b10);

        // reset pulse during ACCESS
        PREADY = 1'b0;
        cmd(1, 0, 32'hC, 32'h0);
        step(); req_valid = 1'b0; step();
        chk("rstmid_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1 chk("rstmid_drop", {PSEL, PENABLE, rsp_valid}, 3'b000);
        step();
        PRESETn = 1'b1;
        PREADY = 1'b1;
        chk("rstmid_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid_quiet", {rsp_valid, PSEL}, 2'b00);
        end

        // PREADY stuck low
        PREADY = 1'b0;
        cmd(1, 0, 32'h10, 32'h0);
        step(); req_valid = 1'b0;
`ifdef APB_CMD_BRIDGE_TIMEOUT_EN
        k = 41;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (rsp_valid === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("tmo_latency", k, 17);
        chk("tmo_rsp", {rsp_err, PSEL, PENABLE, req_ready}, 4'b1001);
        chk("tmo_rdata", rsp_rdata, 0);
`else
        k = 0;
        repeat (100) step();
        chk("stuck_access", {PSEL, PENABLE, rsp_valid}, 3'b110);
        PREADY = 1'b1;
        step();
        chk("stuck_release", {rsp_valid, PSEL}, 2'b10);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
            PREADY    = ($urandom_range(0, 9) < 6);
            PSLVERR   = ($urandom_range(0, 3) == 0);
            PRDATA    = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                #2 PRESETn = 1'b0;
                #3 PRESETn = 1'b1;
            end
        end
        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
